// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station with CDB wakeup and lowest-index issue
module alu_rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        disp_valid,
  input  logic [6:0]  disp_op,
  input  logic [31:0] disp_vi,
  input  logic [31:0] disp_vj,
  input  logic        disp_qi_busy,
  input  logic        disp_qj_busy,
  input  logic [4:0]  disp_qi,
  input  logic [4:0]  disp_qj,
  input  logic [31:0] disp_imm,
  input  logic [4:0]  disp_rd,
  input  logic [31:0] disp_pc,
  input  logic        disp_itype,
  input  logic        cdb_alu_valid,
  input  logic [4:0]  cdb_alu_tag,
  input  logic [31:0] cdb_alu_val,
  input  logic        cdb_lsb_valid,
  input  logic [4:0]  cdb_lsb_tag,
  input  logic [31:0] cdb_lsb_val,
  output logic        rs_full,
  output logic [6:0]  alu_op,
  output logic [31:0] alu_vi,
  output logic [31:0] alu_vj,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic [4:0]  alu_rd,
  output logic        alu_itype
);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qi_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_itype;
  logic [6:0]         r_op  [RS_SIZE];
  logic [31:0]        r_vi  [RS_SIZE];
  logic [31:0]        r_vj  [RS_SIZE];
  logic [31:0]        r_imm [RS_SIZE];
  logic [31:0]        r_pc  [RS_SIZE];
  logic [4:0]         r_qi  [RS_SIZE];
  logic [4:0]         r_qj  [RS_SIZE];
  logic [4:0]         r_rd  [RS_SIZE];

  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_rdy_found;
  logic [IDX_W-1:0] w_rdy_idx;
  logic             w_disp_en;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] f_capture(input logic pend, input logic [4:0] q,
                                            input logic [31:0] v);
    if (pend && cdb_alu_valid && (cdb_alu_tag == q)) return {1'b0, cdb_alu_val};
    if (pend && cdb_lsb_valid && (cdb_lsb_tag == q)) return {1'b0, cdb_lsb_val};
    return {pend, v};
  endfunction

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_busy[i] && !r_qi_busy[i] && !r_qj_busy[i]) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_full   = ~w_free_found;
  assign w_disp_en = disp_valid && w_free_found;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy    <= '0;
      alu_op    <= '0;
      alu_vi    <= '0;
      alu_vj    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_rd    <= '0;
      alu_itype <= 1'b0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_busy <= '0;
        alu_op <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i]) begin
            {r_qi_busy[i], r_vi[i]} <= f_capture(r_qi_busy[i], r_qi[i], r_vi[i]);
            {r_qj_busy[i], r_vj[i]} <= f_capture(r_qj_busy[i], r_qj[i], r_vj[i]);
          end
        end

        if (w_rdy_found) begin
          alu_op            <= r_op[w_rdy_idx];
          alu_vi            <= r_vi[w_rdy_idx];
          alu_vj            <= r_vj[w_rdy_idx];
          alu_imm           <= r_imm[w_rdy_idx];
          alu_pc            <= r_pc[w_rdy_idx];
          alu_rd            <= r_rd[w_rdy_idx];
          alu_itype         <= r_itype[w_rdy_idx];
          r_busy[w_rdy_idx] <= 1'b0;
        end else begin
          alu_op <= '0;
        end

        // The free slot is chosen from pre-edge state, so it never collides with the issued one.
        if (w_disp_en) begin
          r_busy[w_free_idx]  <= 1'b1;
          r_op[w_free_idx]    <= disp_op;
          r_imm[w_free_idx]   <= disp_imm;
          r_pc[w_free_idx]    <= disp_pc;
          r_rd[w_free_idx]    <= disp_rd;
          r_itype[w_free_idx] <= disp_itype;
          r_qi[w_free_idx]    <= disp_qi;
          r_qj[w_free_idx]    <= disp_qj;
          {r_qi_busy[w_free_idx], r_vi[w_free_idx]} <= f_capture(disp_qi_busy, disp_qi, disp_vi);
          {r_qj_busy[w_free_idx], r_vj[w_free_idx]} <= f_capture(disp_qj_busy, disp_qj, disp_vj);
        end
      end
    end
  end

endmodule
